// File: rtl/data_ram_pkg.sv
// data_ram_pkg: sweep FSM state type, read-latency limit and even-parity helper shared by data_ram_pipe
package data_ram_pkg;
  typedef enum logic {CLEAR, READY} ram_state_t;
  localparam int RD_LAT_MAX = 4;
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/data_ram_rdpipe.sv
// data_ram_rdpipe: LAT-stage valid/data shift register (clk, rst, vld_i/dat_i in, vld_o/dat_o out); each stage holds its data while its valid is low
module data_ram_rdpipe #(
  parameter int W   = 8,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);
  for (genvar i = 0; i < LAT; i++) begin : g_stg
    logic         v_in;
    logic [W-1:0] d_in;
    logic         v_q;
    logic [W-1:0] d_q;
    if (i == 0) begin : g_head
      assign v_in = vld_i;
      assign d_in = dat_i;
    end else begin : g_body
      assign v_in = g_stg[i-1].v_q;
      assign d_in = g_stg[i-1].d_q;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= v_in;
        d_q <= v_in ? d_in : d_q;
      end
    end
  end
  assign vld_o = g_stg[LAT-1].v_q;
  assign dat_o = g_stg[LAT-1].d_q;
endmodule

// File: rtl/data_ram_pipe.sv
// data_ram_pipe: swept-clear data RAM with RD_LAT read pipeline (CLK, Reset, MemRead, MemWrite, Address, DataSrc in; DataMemOut, ReadValid, Busy out; ParityErr out with DATA_RAM_PARITY_EN)
module data_ram_pipe
  import data_ram_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [AW-1:0] Address,
  input  logic [DW-1:0] DataSrc,
  output logic [DW-1:0] DataMemOut,
  output logic          ReadValid,
  output logic          Busy
`ifdef DATA_RAM_PARITY_EN
  ,
  output logic          ParityErr
`endif
);
`ifdef DATA_RAM_PARITY_EN
  localparam int WW = DW + 1;
`else
  localparam int WW = DW;
`endif
  localparam logic [AW:0] LAST = (AW+1)'(2**AW - 1);
  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("data_ram_pipe: RD_LAT out of range");
  end
  ram_state_t    state_q, state_d;
  logic [AW:0]   ptr_q, ptr_d;
  logic [WW-1:0] mem [2**AW];
  logic          we, rd_acc, rd_vld;
  logic [AW-1:0] waddr;
  logic [WW-1:0] wdata, rword, pin, pout;
  always_comb begin
    state_d = (state_q == CLEAR && ptr_q == LAST) ? READY : state_q;
    ptr_d   = (state_q == CLEAR) ? ptr_q + 1'b1 : ptr_q;
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end
  assign Busy   = state_q == CLEAR;
  assign we     = !Reset && (Busy || MemWrite);
  assign waddr  = Busy ? ptr_q[AW-1:0] : Address;
  assign rd_acc = !Reset && !Busy && MemRead;
  assign rword  = mem[Address];
`ifdef DATA_RAM_PARITY_EN
  assign wdata      = Busy ? '0 : {even_parity(32'(DataSrc)), DataSrc};
  assign pin        = {rword[DW] ^ even_parity(32'(rword[DW-1:0])), rword[DW-1:0]};
  assign DataMemOut = pout[DW-1:0];
  assign ParityErr  = rd_vld & pout[DW];
`else
  assign wdata      = Busy ? '0 : DataSrc;
  assign pin        = rword;
  assign DataMemOut = pout;
`endif
  assign ReadValid = rd_vld;
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end
  data_ram_rdpipe #(.W(WW), .LAT(RD_LAT)) u_rdpipe (
    .clk  (CLK),
    .rst  (Reset),
    .vld_i(rd_acc),
    .dat_i(pin),
    .vld_o(rd_vld),
    .dat_o(pout)
  );
endmodule

// File: tb/tb_data_ram_pipe.sv
// tb_data_ram_pipe: scoreboard bench for data_ram_pipe (DW=8, AW=8, RD_LAT=3)
module tb_data_ram_pipe;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int RL = 3;
  typedef struct {
    logic [DW-1:0] d;
    int            due;
    logic          pe;
  } exp_t;
  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          MemRead = 1'b0;
  logic          MemWrite = 1'b0;
  logic [AW-1:0] Address = '0;
  logic [DW-1:0] DataSrc = '0;
  logic [DW-1:0] DataMemOut;
  logic          ReadValid;
  logic          Busy;
`ifdef DATA_RAM_PARITY_EN
  logic          ParityErr;
`endif
  exp_t          q[$];
  logic [DW-1:0] mdl [2**AW];
  int            cyc = 0;
  int            vecs = 0;
  int            errs = 0;
  int            rv_seen = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  data_ram_pipe #(.DW(DW), .AW(AW), .RD_LAT(RL)) dut (
    .CLK       (clk),
    .Reset     (Reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .DataSrc   (DataSrc),
    .DataMemOut(DataMemOut),
    .ReadValid (ReadValid),
`ifdef DATA_RAM_PARITY_EN
    .ParityErr (ParityErr),
`endif
    .Busy      (Busy)
  );
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      vecs++;
      errs++;
      $display("FAIL rd_missing: no ReadValid by cycle %0d, required at cycle %0d (data %h)", cyc, e.due, e.d);
    end
    if (ReadValid === 1'b1) begin
      rv_seen++;
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL rd_stray: ReadValid=1 at cycle %0d data %h, required no pending read", cyc, DataMemOut);
      end else begin
        e = q.pop_front();
        vecs++;
        if (DataMemOut !== e.d) begin
          errs++;
          $display("FAIL rd_data: DataMemOut=%h, required %h", DataMemOut, e.d);
        end
        vecs++;
        if (cyc !== e.due) begin
          errs++;
          $display("FAIL rd_latency: ReadValid at cycle %0d, required cycle %0d", cyc, e.due);
        end
`ifdef DATA_RAM_PARITY_EN
        vecs++;
        if (ParityErr !== e.pe) begin
          errs++;
          $display("FAIL rd_parity: ParityErr=%b, required %b", ParityErr, e.pe);
        end
`endif
      end
    end
  end
  task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic pe = 1'b0);
    @(negedge clk);
    MemRead  = rd;
    MemWrite = wr;
    Address  = a;
    DataSrc  = d;
    if (rd) q.push_back(exp_t'{mdl[a], cyc + RL, pe});
    if (wr) mdl[a] = d;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, '0);
  endtask
  task automatic drain();
    int t;
    t = 0;
    idle(1);
    while (q.size() != 0 && t < RL + 10) begin
      @(negedge clk);
      t++;
    end
    vecs++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d reads still pending, required 0", q.size());
      q.delete();
    end
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Reset    = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    q.delete();
    foreach (mdl[i]) mdl[i] = '0;
  endtask
  task automatic measure_busy(output int n, input bit poke);
    n = 0;
    while (Busy === 1'b1 && n < 1000) begin
      n++;
      MemWrite = poke && n >= 10 && n <= 20;
      MemRead  = MemWrite;
      Address  = 8'h05;
      DataSrc  = 8'hFF;
      @(negedge clk);
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask
  task automatic test_reset();
    int n;
    pulse_reset();
    vecs++;
    if (Busy !== 1'b1) begin
      errs++;
      $display("FAIL reset_busy: Busy=%b, required 1", Busy);
    end
    vecs++;
    if (ReadValid !== 1'b0) begin
      errs++;
      $display("FAIL reset_valid: ReadValid=%b, required 0", ReadValid);
    end
    vecs++;
    if (DataMemOut !== 8'h00) begin
      errs++;
      $display("FAIL reset_data: DataMemOut=%h, required 00", DataMemOut);
    end
    measure_busy(n, 1'b0);
    vecs++;
    if (n !== 256) begin
      errs++;
      $display("FAIL busy_len: Busy lasted %0d cycles, required 256", n);
    end
    drive(1'b1, 1'b0, 8'h00, '0);
    drive(1'b1, 1'b0, 8'h7F, '0);
    drive(1'b1, 1'b0, 8'hFF, '0);
    drain();
  endtask
  task automatic test_write_read();
    drive(1'b0, 1'b1, 8'h10, 8'hA5);
    drive(1'b1, 1'b0, 8'h10, '0);
    drain();
  endtask
  task automatic test_collision();
    drive(1'b0, 1'b1, 8'h20, 8'h11);
    drive(1'b1, 1'b1, 8'h20, 8'h22);
    drive(1'b1, 1'b0, 8'h20, '0);
    drain();
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'(i), 8'(i + 1));
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'(i), '0);
    drain();
    idle(3);
    vecs++;
    if (ReadValid !== 1'b0) begin
      errs++;
      $display("FAIL hold_valid: ReadValid=%b, required 0", ReadValid);
    end
    vecs++;
    if (DataMemOut !== 8'h08) begin
      errs++;
      $display("FAIL hold_data: DataMemOut=%h, required 08", DataMemOut);
    end
  endtask
  task automatic test_reset_mid();
    int n, rv0;
    drive(1'b0, 1'b1, 8'h05, 8'h77);
    @(negedge clk);
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    Address  = 8'h05;
    rv0 = rv_seen;
    pulse_reset();
    repeat (99) @(negedge clk);
    vecs++;
    if (rv_seen !== rv0) begin
      errs++;
      $display("FAIL discarded_read: %0d ReadValid pulses after reset, required 0", rv_seen - rv0);
    end
    pulse_reset();
    measure_busy(n, 1'b1);
    vecs++;
    if (n !== 256) begin
      errs++;
      $display("FAIL busy_restart_len: Busy lasted %0d cycles, required 256", n);
    end
    drive(1'b1, 1'b0, 8'h05, '0);
    drain();
  endtask
`ifdef DATA_RAM_PARITY_EN
  task automatic test_parity();
    drive(1'b0, 1'b1, 8'h30, 8'h03);
    drive(1'b0, 1'b1, 8'h31, 8'h03);
    idle(1);
    dut.mem[8'h30][DW] = ~dut.mem[8'h30][DW];
    drive(1'b1, 1'b0, 8'h30, '0, 1'b1);
    drive(1'b1, 1'b0, 8'h31, '0, 1'b0);
    drain();
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_back_to_back();
    test_reset_mid();
`ifdef DATA_RAM_PARITY_EN
    test_parity();
`endif
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
